prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 141 ++++++++++++++
 tb/tb_prbs_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS checker: seeds from the received LFSR stream, locks after a run of good words,
// then free-runs its own prediction and counts mismatches until lock is lost.
module prbs_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = '0,
    parameter int                    LOCK_CNT   = 8,
    parameter int                    ERR_THRESH = 4,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  locked_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [1:0]            state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_LOCK = 2'd3;

    localparam logic [7:0]            LOCK_LIM = 8'(LOCK_CNT);
    localparam logic [7:0]            ERR_LIM  = 8'(ERR_THRESH);
    localparam logic [7:0]            ONE8     = 8'd1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    // The top bit of the shifted word only ever receives the old bit 0, so its tap is masked off.
    localparam logic [DATA_WIDTH-1:0] TAPS     = {1'b0, POLY[DATA_WIDTH-2:0]};

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [7:0]            good_q, good_d;
    logic [7:0]            bad_q, bad_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  locked_q, locked_d;

    logic [DATA_WIDTH-1:0] pred;
    logic                  datZero;
    logic                  hit;

    assign pred    = {exp_q[0], exp_q[DATA_WIDTH-1:1]} ^ (TAPS & {DATA_WIDTH{exp_q[0]}});
    assign datZero = (dat_i == '0);
    assign hit     = !datZero && (dat_i == pred);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SEED;
                ST_SEED: begin
                    if (vld_i && !datZero) begin
                        exp_d   = dat_i;
                        good_d  = '0;
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (vld_i) begin
                        if (hit) begin
                            exp_d  = dat_i;
                            good_d = good_q + ONE8;
                            if (good_q + ONE8 == LOCK_LIM) begin
                                state_d = ST_LOCK;
                                bad_d   = '0;
                            end
                        end else if (datZero) begin
                            good_d  = '0;
                            state_d = ST_SEED;
                        end else begin
                            exp_d  = dat_i;
                            good_d = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    // Flywheel: the prediction advances on every beat, good or bad.
                    if (vld_i) begin
                        exp_d = pred;
                        if (hit) begin
                            bad_d = '0;
                        end else begin
                            err_d = 1'b1;
                            bad_d = bad_q + ONE8;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                            if (bad_q + ONE8 == ERR_LIM) begin
                                state_d = ST_SYNC;
                                exp_d   = dat_i;
                                good_d  = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (clr_i) begin
            cnt_d = '0;
        end
        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker: directed scenarios plus randomized traffic against a
// beat-level reference model; two instances differ only in error counter width.
module tb_prbs_checker;

    localparam int         DW     = 4;
    localparam logic [3:0] POLY_P = 4'h1;
    localparam int         LOCKN  = 2;
    localparam int         THRESH = 4;
    localparam int         MAXA   = 255;
    localparam int         MAXB   = 3;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       vld = 1'b0;
    logic [3:0] dat = 4'h0;

    logic       lockedA, errA, lockedB, errB;
    logic [7:0] cntA;
    logic [1:0] cntB;
    logic [1:0] stateA, stateB;

    int vectors = 0;
    int miscompares = 0;

    int mState, mExp, mGood, mBad, mCntA, mCntB;
    bit mErr;

    prbs_checker #(.DATA_WIDTH(DW), .POLY(POLY_P), .LOCK_CNT(LOCKN), .ERR_THRESH(THRESH), .CNT_WIDTH(8)) dutA (
        .clk_i(clk), .rst_n_i(rstN), .en_i(en), .clr_i(clr), .vld_i(vld), .dat_i(dat),
        .locked_o(lockedA), .err_o(errA), .err_cnt_o(cntA), .state_o(stateA)
    );

    prbs_checker #(.DATA_WIDTH(DW), .POLY(POLY_P), .LOCK_CNT(LOCKN), .ERR_THRESH(THRESH), .CNT_WIDTH(2)) dutB (
        .clk_i(clk), .rst_n_i(rstN), .en_i(en), .clr_i(clr), .vld_i(vld), .dat_i(dat),
        .locked_o(lockedB), .err_o(errB), .err_cnt_o(cntB), .state_o(stateB)
    );

    always #5 clk = ~clk;

    // One generator step: shift right, and when the dropped bit is set fold in the top bit plus taps.
    function automatic int stepM(input int q);
        int msb;
        int taps;
        msb  = 1 << (DW - 1);
        taps = int'(POLY_P) & (msb - 1);
        return (q >> 1) ^ (((q & 1) != 0) ? (msb | taps) : 0);
    endfunction

    function automatic void modelReset();
        mState = 0; mExp = 0; mGood = 0; mBad = 0;
        mCntA = 0; mCntB = 0; mErr = 1'b0;
    endfunction

    function automatic void modelUpdate(input bit e, input bit c, input bit v, input int d);
        int  p;
        bit  good;
        p    = stepM(mExp);
        good = (d != 0) && (d == p);
        mErr = 1'b0;
        if (!e) begin
            mState = 0;
        end else if (mState == 0) begin
            mState = 1;
        end else if (mState == 1) begin
            if (v && d != 0) begin
                mExp = d; mGood = 0; mState = 2;
            end
        end else if (mState == 2) begin
            if (v) begin
                if (good) begin
                    mExp = d; mGood++;
                    if (mGood == LOCKN) begin
                        mState = 3; mBad = 0;
                    end
                end else if (d == 0) begin
                    mGood = 0; mState = 1;
                end else begin
                    mExp = d; mGood = 0;
                end
            end
        end else begin
            if (v) begin
                mExp = p;
                if (good) begin
                    mBad = 0;
                end else begin
                    mErr = 1'b1;
                    mBad++;
                    if (mCntA < MAXA) mCntA++;
                    if (mCntB < MAXB) mCntB++;
                    if (mBad == THRESH) begin
                        mState = 2; mExp = d; mGood = 0;
                    end
                end
            end
        end
        if (c) begin
            mCntA = 0; mCntB = 0;
        end
    endfunction

    function automatic logic [3:0] nextGood();
        return 4'(stepM(mExp));
    endfunction

    function automatic logic [3:0] badWord();
        int w;
        do w = int'($urandom_range(15, 1)); while (w == stepM(mExp));
        return 4'(w);
    endfunction

    task automatic applyStimulus(input bit e, input bit c, input bit v, input logic [3:0] d);
        en = e; clr = c; vld = v; dat = d;
        @(posedge clk);
        modelUpdate(e, c, v, int'(d));
        #1;
    endtask

    task automatic test_reset();
        modelReset();
        #3;
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %b expected 0", lockedA); end
        vectors++; if (errA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", errA); end
        vectors++; if (cntA !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cntA); end
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", stateA); end
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 4'h0);
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got %0d expected 0", stateA); end
    endtask

    task automatic test_lock_acquire();
        applyStimulus(1, 0, 0, 4'h0);
        vectors++; if (stateA !== 2'd1) begin miscompares++; $display("[TB] FAIL acq_seed: got %0d expected 1", stateA); end
        applyStimulus(1, 0, 1, 4'h1);
        vectors++; if (stateA !== 2'd2) begin miscompares++; $display("[TB] FAIL acq_sync: got %0d expected 2", stateA); end
        applyStimulus(1, 0, 1, 4'h9);
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL acq_early_lock: got %b expected 0", lockedA); end
        applyStimulus(1, 0, 1, 4'hD);
        vectors++; if (lockedA !== 1'b1) begin miscompares++; $display("[TB] FAIL acq_locked: got %b expected 1", lockedA); end
        vectors++; if (stateA !== 2'd3) begin miscompares++; $display("[TB] FAIL acq_state: got %0d expected 3", stateA); end
        vectors++; if (cntA !== 8'd0) begin miscompares++; $display("[TB] FAIL acq_cnt: got %0d expected 0", cntA); end
    endtask

    task automatic test_single_error();
        applyStimulus(1, 0, 1, 4'h3);
        vectors++; if (errA !== 1'b1) begin miscompares++; $display("[TB] FAIL single_err_pulse: got %b expected 1", errA); end
        vectors++; if (cntA !== 8'd1) begin miscompares++; $display("[TB] FAIL single_err_cnt: got %0d expected 1", cntA); end
        applyStimulus(1, 0, 1, 4'hE);
        vectors++; if (errA !== 1'b0) begin miscompares++; $display("[TB] FAIL single_err_width: got %b expected 0", errA); end
        applyStimulus(1, 0, 1, 4'h7);
        vectors++; if (lockedA !== 1'b1) begin miscompares++; $display("[TB] FAIL single_err_locked: got %b expected 1", lockedA); end
        vectors++; if (cntA !== 8'd1) begin miscompares++; $display("[TB] FAIL single_err_hold: got %0d expected 1", cntA); end
    endtask

    task automatic test_loss_of_lock();
        applyStimulus(1, 1, 0, 4'h0);
        vectors++; if (cntA !== 8'd0) begin miscompares++; $display("[TB] FAIL loss_clr: got %0d expected 0", cntA); end
        for (int i = 0; i < THRESH; i++) begin
            applyStimulus(1, 0, 1, badWord());
            vectors++; if (errA !== 1'b1) begin miscompares++; $display("[TB] FAIL loss_err[%0d]: got %b expected 1", i, errA); end
            if (i < THRESH - 1) begin
                vectors++; if (lockedA !== 1'b1) begin miscompares++; $display("[TB] FAIL loss_early[%0d]: got %b expected 1", i, lockedA); end
            end
        end
        vectors++; if (cntA !== 8'd4) begin miscompares++; $display("[TB] FAIL loss_cnt: got %0d expected 4", cntA); end
        vectors++; if (cntB !== 2'd3) begin miscompares++; $display("[TB] FAIL loss_cnt_sat: got %0d expected 3", cntB); end
        vectors++; if (stateA !== 2'd2) begin miscompares++; $display("[TB] FAIL loss_state: got %0d expected 2", stateA); end
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL loss_unlocked: got %b expected 0", lockedA); end
        applyStimulus(1, 0, 1, nextGood());
        vectors++; if (stateA !== 2'd2) begin miscompares++; $display("[TB] FAIL relock_mid: got %0d expected 2", stateA); end
        applyStimulus(1, 0, 1, nextGood());
        vectors++; if (lockedA !== 1'b1) begin miscompares++; $display("[TB] FAIL relock: got %b expected 1", lockedA); end
    endtask

    task automatic test_zero_word();
        applyStimulus(0, 0, 0, 4'h0);
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("[TB] FAIL disable_idle: got %0d expected 0", stateA); end
        vectors++; if (cntA !== 8'd4) begin miscompares++; $display("[TB] FAIL disable_retain: got %0d expected 4", cntA); end
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 0, 1, 4'h0);
        vectors++; if (stateA !== 2'd1) begin miscompares++; $display("[TB] FAIL zero_seed: got %0d expected 1", stateA); end
        applyStimulus(1, 0, 1, 4'h5);
        vectors++; if (stateA !== 2'd2) begin miscompares++; $display("[TB] FAIL zero_seeded: got %0d expected 2", stateA); end
        applyStimulus(1, 0, 1, 4'h0);
        vectors++; if (stateA !== 2'd1) begin miscompares++; $display("[TB] FAIL zero_sync: got %0d expected 1", stateA); end
        applyStimulus(1, 0, 1, 4'h5);
        applyStimulus(1, 0, 1, nextGood());
        applyStimulus(1, 0, 1, nextGood());
        vectors++; if (stateA !== 2'd3) begin miscompares++; $display("[TB] FAIL zero_relock: got %0d expected 3", stateA); end
        applyStimulus(1, 0, 1, 4'h0);
        vectors++; if (errA !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_lock_err: got %b expected 1", errA); end
        vectors++; if (cntA !== 8'd5) begin miscompares++; $display("[TB] FAIL zero_lock_cnt: got %0d expected 5", cntA); end
    endtask

    task automatic test_saturation_clear();
        applyStimulus(1, 1, 0, 4'h0);
        applyStimulus(1, 0, 1, nextGood());
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, (i == 3) ? nextGood() : badWord());
        end
        vectors++; if (cntA !== 8'd5) begin miscompares++; $display("[TB] FAIL sat_wide: got %0d expected 5", cntA); end
        vectors++; if (cntB !== 2'd3) begin miscompares++; $display("[TB] FAIL sat_narrow: got %0d expected 3", cntB); end
        vectors++; if (lockedB !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_locked: got %b expected 1", lockedB); end
        applyStimulus(1, 1, 1, badWord());
        vectors++; if (errB !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_err_pulse: got %b expected 1", errB); end
        vectors++; if (cntB !== 2'd0) begin miscompares++; $display("[TB] FAIL clr_wins: got %0d expected 0", cntB); end
        vectors++; if (cntA !== 8'd0) begin miscompares++; $display("[TB] FAIL clr_wins_wide: got %0d expected 0", cntA); end
    endtask

    task automatic test_disable_reset();
        applyStimulus(1, 0, 1, nextGood());
        applyStimulus(1, 0, 1, badWord());
        applyStimulus(0, 0, 1, nextGood());
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("[TB] FAIL dis_state: got %0d expected 0", stateA); end
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL dis_locked: got %b expected 0", lockedA); end
        vectors++; if (cntA !== 8'd1) begin miscompares++; $display("[TB] FAIL dis_retain: got %0d expected 1", cntA); end
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 0, 1, 4'(int'($urandom_range(15, 1))));
        applyStimulus(1, 0, 1, nextGood());
        applyStimulus(1, 0, 1, nextGood());
        applyStimulus(1, 0, 1, badWord());
        vectors++; if (errA !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_rst_err: got %b expected 1", errA); end
        #2;
        en = 1'b0; vld = 1'b0;
        rstN = 1'b0;
        modelReset();
        #1;
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_locked: got %b expected 0", lockedA); end
        vectors++; if (errA !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_err: got %b expected 0", errA); end
        vectors++; if (cntA !== 8'd0) begin miscompares++; $display("[TB] FAIL arst_cnt: got %0d expected 0", cntA); end
        vectors++; if (stateA !== 2'd0) begin miscompares++; $display("[TB] FAIL arst_state: got %0d expected 0", stateA); end
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1, 0, 1, 4'h1);
        vectors++; if (stateA !== 2'd1) begin miscompares++; $display("[TB] FAIL rst_fresh_seed: got %0d expected 1", stateA); end
        applyStimulus(1, 0, 1, 4'h1);
        applyStimulus(1, 0, 1, 4'h9);
        vectors++; if (lockedA !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_no_early_lock: got %b expected 0", lockedA); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        for (int i = 0; i < 120; i++) begin
            d = ($urandom_range(0, 9) == 0) ? badWord() : nextGood();
            applyStimulus(1, 0, 1, d);
            vectors++; if (stateA !== 2'(mState)) begin miscompares++; $display("[TB] FAIL b2b_state[%0d]: got %0d expected %0d", i, stateA, mState); end
            vectors++; if (errA !== mErr) begin miscompares++; $display("[TB] FAIL b2b_err[%0d]: got %b expected %b", i, errA, mErr); end
            vectors++; if (cntA !== 8'(mCntA)) begin miscompares++; $display("[TB] FAIL b2b_cnt[%0d]: got %0d expected %0d", i, cntA, mCntA); end
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        int         kind;
        bit         e, c, v;
        for (int i = 0; i < 600; i++) begin
            e    = ($urandom_range(0, 24) != 0);
            c    = ($urandom_range(0, 29) == 0);
            v    = ($urandom_range(0, 3) != 0);
            kind = int'($urandom_range(0, 19));
            if (kind < 12)      d = nextGood();
            else if (kind < 17) d = 4'($urandom_range(0, 15));
            else                d = 4'h0;
            applyStimulus(e, c, v, d);
            vectors++; if (stateA !== 2'(mState)) begin miscompares++; $display("[TB] FAIL rnd_state[%0d]: got %0d expected %0d", i, stateA, mState); end
            vectors++; if (lockedA !== (mState == 3)) begin miscompares++; $display("[TB] FAIL rnd_locked[%0d]: got %b expected %b", i, lockedA, mState == 3); end
            vectors++; if (errA !== mErr) begin miscompares++; $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", i, errA, mErr); end
            vectors++; if (cntA !== 8'(mCntA)) begin miscompares++; $display("[TB] FAIL rnd_cnt[%0d]: got %0d expected %0d", i, cntA, mCntA); end
            vectors++; if (cntB !== 2'(mCntB)) begin miscompares++; $display("[TB] FAIL rnd_cnt_sat[%0d]: got %0d expected %0d", i, cntB, mCntB); end
            vectors++; if (stateB !== 2'(mState)) begin miscompares++; $display("[TB] FAIL rnd_stateB[%0d]: got %0d expected %0d", i, stateB, mState); end
        end
    endtask

    initial begin
        $display("[TB] prbs_checker bench start");
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_loss_of_lock();
        test_zero_word();
        test_saturation_clear();
        test_disable_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
